// File: rtl/counter_pkg.sv
// Shared types and default widths for the programmable up/down counter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package counter_pkg;

  localparam int unsigned DEF_COUNT_WIDTH = 8;
  localparam int unsigned DEF_STEP_WIDTH  = 4;

  // End-of-range behaviour; the reserved encoding is treated as saturate.
  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_SAT     = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

endpackage

// File: rtl/counter_step_calc.sv
// Next-count arithmetic for one enabled step inside the range [0, limit].
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the result is used.
module counter_step_calc
  import counter_pkg::*;
#(
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic [COUNT_WIDTH-1:0] count_i,
  input  logic [COUNT_WIDTH-1:0] eff_i,
  input  logic [COUNT_WIDTH-1:0] limit_i,
  input  logic                   up_dn_i,
  input  mode_e                  mode_i,
  output logic [COUNT_WIDTH-1:0] next_count_o,
  output logic                   cross_up_o,
  output logic                   cross_dn_o,
  output logic                   set_halt_o
);

  // One extra bit so that count+eff and limit+1 never wrap at 2^COUNT_WIDTH.
  logic [COUNT_WIDTH:0] count_x;
  logic [COUNT_WIDTH:0] eff_x;
  logic [COUNT_WIDTH:0] limit_x;
  logic [COUNT_WIDTH:0] lim_p1;
  logic [COUNT_WIDTH:0] sum_up;
  logic [COUNT_WIDTH:0] wrap_up;
  logic [COUNT_WIDTH:0] wrap_dn;
  logic [COUNT_WIDTH-1:0] diff_dn;

  assign count_x = {1'b0, count_i};
  assign eff_x   = {1'b0, eff_i};
  assign limit_x = {1'b0, limit_i};
  assign lim_p1  = limit_x + 1'b1;
  assign sum_up  = count_x + eff_x;
  // Only used when sum_up > limit, so the subtraction cannot underflow.
  assign wrap_up = sum_up - lim_p1;
  // Only used when count < eff; the result lands back inside [0, limit].
  assign wrap_dn = count_x + lim_p1 - eff_x;
  assign diff_dn = count_i - eff_i;

  // Select the in-range result or the mode-specific end-of-range result.
  always_comb begin
    next_count_o = count_i;
    cross_up_o   = 1'b0;
    cross_dn_o   = 1'b0;
    set_halt_o   = 1'b0;
    if (up_dn_i) begin
      if (sum_up <= limit_x) begin
        next_count_o = sum_up[COUNT_WIDTH-1:0];
      end else begin
        cross_up_o = 1'b1;
        case (mode_i)
          MODE_WRAP: next_count_o = wrap_up[COUNT_WIDTH-1:0];
          MODE_ONESHOT: begin
            next_count_o = limit_i;
            set_halt_o   = 1'b1;
          end
          default: next_count_o = limit_i;
        endcase
      end
    end else begin
      if (count_i >= eff_i) begin
        next_count_o = diff_dn;
      end else begin
        cross_dn_o = 1'b1;
        case (mode_i)
          MODE_WRAP: next_count_o = wrap_dn[COUNT_WIDTH-1:0];
          MODE_ONESHOT: begin
            next_count_o = '0;
            set_halt_o   = 1'b1;
          end
          default: next_count_o = '0;
        endcase
      end
    end
  end

endmodule

// File: rtl/updown_counter_prog.sv
// Programmable up/down counter: step, live limit, clear/load, wrap/sat/one-shot.
// Latency: count and ovf/unf/halted register on the same edge; at_max/at_min are combinational.
// Backpressure: none; en gates counting, halted freezes it until clr/load/rst.
module updown_counter_prog
  import counter_pkg::*;
#(
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
  parameter int STEP_WIDTH  = DEF_STEP_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   load,
  input  logic [COUNT_WIDTH-1:0] load_val,
  input  logic                   en,
  input  logic                   up_dn,
  input  logic [STEP_WIDTH-1:0]  step,
  input  logic [COUNT_WIDTH-1:0] limit,
  input  logic [1:0]             mode,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   at_max,
  output logic                   at_min,
  output logic                   ovf,
  output logic                   unf,
  output logic                   halted
);

  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   unf_q, unf_d;
  logic                   halted_q, halted_d;

  logic [COUNT_WIDTH-1:0] step_ext;
  logic [COUNT_WIDTH-1:0] eff;
  logic [COUNT_WIDTH-1:0] load_clip;
  logic [COUNT_WIDTH-1:0] next_count;
  logic                   cross_up;
  logic                   cross_dn;
  logic                   set_halt;

  // A step larger than the whole range is clamped so wrap arithmetic stays single-lap.
  assign step_ext  = COUNT_WIDTH'(step);
  assign eff       = (step_ext < limit) ? step_ext : limit;
  assign load_clip = (load_val < limit) ? load_val : limit;

  counter_step_calc #(
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_step_calc (
    .count_i      (count_q),
    .eff_i        (eff),
    .limit_i      (limit),
    .up_dn_i      (up_dn),
    .mode_i       (mode_e'(mode)),
    .next_count_o (next_count),
    .cross_up_o   (cross_up),
    .cross_dn_o   (cross_dn),
    .set_halt_o   (set_halt)
  );

  // Priority mux: clr > load > enabled step; pulses default low every cycle.
  always_comb begin
    count_d  = count_q;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    halted_d = halted_q;
    if (clr) begin
      count_d  = '0;
      halted_d = 1'b0;
    end else if (load) begin
      count_d  = load_clip;
      halted_d = 1'b0;
    end else if (en && !halted_q) begin
      if (count_q > limit) begin
        // Limit was lowered under us: pull back into range without an event.
        count_d = limit;
      end else begin
        count_d = next_count;
        ovf_d   = cross_up;
        unf_d   = cross_dn;
        if (set_halt) begin
          halted_d = 1'b1;
        end
      end
    end
  end

  // State registers with synchronous reset taking priority over all controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      halted_q <= halted_d;
    end
  end

  assign count  = count_q;
  assign ovf    = ovf_q;
  assign unf    = unf_q;
  assign halted = halted_q;
  assign at_max = (count_q == limit);
  assign at_min = (count_q == '0);

endmodule
